// File: rtl/async_fifo_core_pkg.sv
// Shared defaults for the FIFO slice: word width, address width and derived depth.
package async_fifo_core_pkg;
  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 4;
  localparam int DEPTH                 = 1 << DEFAULT_ADDRESS_WIDTH;
endpackage

// File: rtl/async_fifo_core_if.sv
// Producer/consumer handshake bundle; the FIFO takes the slave side.
interface async_fifo_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_full;
  logic                  fifo_empty;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, fifo_full, fifo_empty
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, fifo_full, fifo_empty
  );
endinterface

// File: rtl/async_fifo_core_fifo_mem.sv
// Simple dual-port storage: synchronous write, address-indexed combinational read.
module fifo_mem
  import async_fifo_core_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  localparam int WORDS = 1 << ADDRESS_WIDTH;

  // Contents are deliberately not reset; the pointers define what is valid.
  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/async_fifo_core.sv
// Single-clock FIFO: wrap-bit pointers, flag decode from registered pointers, registered read data.
module async_fifo_core
  import async_fifo_core_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input logic              clk,
  input logic              rst,
  async_fifo_core_if.slave bus
);
  localparam logic [ADDRESS_WIDTH:0] PTR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH:0]  wr_ptr;
  logic [ADDRESS_WIDTH:0]  rd_ptr;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    full;
  logic                    empty;
  logic                    wr_ok;
  logic                    rd_ok;

  // Flags depend only on registered pointers, never on the request inputs.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]) &&
            (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0]);
    wr_ok = bus.wr_en && !full;
    rd_ok = bus.rd_en && !empty;
  end

  fifo_mem #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr[ADDRESS_WIDTH-1:0]),
    .wdata(bus.data_in),
    .raddr(rd_ptr[ADDRESS_WIDTH-1:0]),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        data_out_q <= rd_word;
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
endmodule

// File: tb/tb_async_fifo_core.sv
// Randomized self-checking bench for async_fifo_core against a queue-based reference model.
module tb_async_fifo_core;
  import async_fifo_core_pkg::*;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  logic [7:0] model_q[$];
  logic [7:0] m_out;

  async_fifo_core_if #(.DATA_WIDTH(DEFAULT_DATA_WIDTH)) bus ();

  async_fifo_core #(
    .DATA_WIDTH   (DEFAULT_DATA_WIDTH),
    .ADDRESS_WIDTH(DEFAULT_ADDRESS_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given requests; the model sees the pre-edge occupancy.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit pre_full;
    bit pre_empty;
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    @(posedge clk);
    if (!rst) begin
      pre_full  = (model_q.size() == DEPTH);
      pre_empty = (model_q.size() == 0);
      if (r && !pre_empty) m_out = model_q.pop_front();
      if (w && !pre_full) model_q.push_back(d);
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_q.delete();
    m_out = 8'h00;
    total++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.data_out !== 8'h00)
      $display("FAIL reset_initial: empty=%b full=%b data_out=%h, expected 1 0 00",
               bus.fifo_empty, bus.fifo_full, bus.data_out);
    else passed++;
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h4D, 1'b0);
    cycle(1'b1, 8'h5E, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (bus.data_out !== 8'h3C)
      $display("FAIL reset_preload_read: data_out=%h expected 3c", bus.data_out);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.data_out !== 8'h00)
      $display("FAIL reset_async: empty=%b full=%b data_out=%h, expected 1 0 00",
               bus.fifo_empty, bus.fifo_full, bus.data_out);
    else passed++;
    model_q.delete();
    m_out = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 15) begin
        total++;
        if (bus.fifo_full !== 1'b0) $display("FAIL fill_15_not_full: full=%b expected 0", bus.fifo_full);
        else passed++;
      end
    end
    total++;
    if (bus.fifo_full !== 1'b1 || bus.fifo_empty !== 1'b0)
      $display("FAIL fill_16_full: full=%b empty=%b expected 1 0", bus.fifo_full, bus.fifo_empty);
    else passed++;
    cycle(1'b1, 8'd99, 1'b0);
    total++;
    if (bus.fifo_full !== 1'b1) $display("FAIL fill_overflow: full=%b expected 1", bus.fifo_full);
    else passed++;
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if (bus.data_out !== 8'((i <= 16) ? i : 16))
        $display("FAIL drain_data[%0d]: data_out=%0d expected %0d", i, bus.data_out, (i <= 16) ? i : 16);
      else passed++;
      if (i == 15 || i == 16) begin
        total++;
        if (bus.fifo_empty !== (i == 16))
          $display("FAIL drain_empty[%0d]: empty=%b expected %b", i, bus.fifo_empty, (i == 16));
        else passed++;
      end
    end
  endtask

  task automatic test_wrap();
    for (int phase = 0; phase < 4; phase++) begin
      for (int i = 0; i < 10; i++) begin
        if (phase % 2 == 0) cycle(1'b1, 8'($urandom), 1'b0);
        else cycle(1'b0, 8'h00, 1'b1);
        total++;
        if (bus.data_out !== m_out || bus.fifo_full !== (model_q.size() == DEPTH) ||
            bus.fifo_empty !== (model_q.size() == 0))
          $display("FAIL wrap[%0d.%0d]: data_out=%h full=%b empty=%b expected %h %b %b", phase, i,
                   bus.data_out, bus.fifo_full, bus.fifo_empty, m_out,
                   (model_q.size() == DEPTH), (model_q.size() == 0));
        else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] held;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1);
      total++;
      if (bus.data_out !== m_out || bus.fifo_full !== 1'b0 || bus.fifo_empty !== 1'b0 || model_q.size() != 5)
        $display("FAIL simul_mid[%0d]: data_out=%h full=%b empty=%b expected %h 0 0",
                 i, bus.data_out, bus.fifo_full, bus.fifo_empty, m_out);
      else passed++;
    end
    while (model_q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    total++;
    if (bus.data_out !== m_out || bus.fifo_full !== 1'b0 || model_q.size() != DEPTH - 1)
      $display("FAIL simul_full: data_out=%h full=%b expected %h 0", bus.data_out, bus.fifo_full, m_out);
    else passed++;
    while (model_q.size() > 0) begin
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if (bus.data_out !== m_out)
        $display("FAIL simul_full_drain: data_out=%h expected %h", bus.data_out, m_out);
      else passed++;
    end
    held = m_out;
    cycle(1'b1, 8'h77, 1'b1);
    total++;
    if (bus.data_out !== held || bus.fifo_empty !== 1'b0)
      $display("FAIL simul_empty: data_out=%h empty=%b expected %h 0", bus.data_out, bus.fifo_empty, held);
    else passed++;
    cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (bus.data_out !== 8'h77 || bus.fifo_empty !== 1'b1)
      $display("FAIL simul_empty_read: data_out=%h empty=%b expected 77 1", bus.data_out, bus.fifo_empty);
    else passed++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        rst = 1'b1;
        model_q.delete();
        m_out = 8'h00;
      end
      cycle(1'b1, 8'(8'h10 + i), 1'b0);
    end
    rst = 1'b0;
    total++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.data_out !== 8'h00)
      $display("FAIL midreset_state: empty=%b full=%b data_out=%h expected 1 0 00",
               bus.fifo_empty, bus.fifo_full, bus.data_out);
    else passed++;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    total++;
    if (bus.data_out !== 8'hA5 || bus.fifo_empty !== 1'b1)
      $display("FAIL midreset_a5: data_out=%h empty=%b expected a5 1", bus.data_out, bus.fifo_empty);
    else passed++;
  endtask

  task automatic test_random();
    logic w;
    logic r;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 70));
      cycle(w, 8'($urandom), r);
      total++;
      if (bus.data_out !== m_out || bus.fifo_full !== (model_q.size() == DEPTH) ||
          bus.fifo_empty !== (model_q.size() == 0))
        $display("FAIL random[%0d]: data_out=%h full=%b empty=%b expected %h %b %b", i,
                 bus.data_out, bus.fifo_full, bus.fifo_empty, m_out,
                 (model_q.size() == DEPTH), (model_q.size() == 0));
      else passed++;
    end
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    m_out       = 8'h00;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = 8'h00;
    rst         = 1'b1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
